nibble_serial_addsub_ctrl: RTL and testbench
============================================

# nibble_serial_addsub_ctrl

Multi-cycle controller that performs wide add/subtract on a single shared 4-bit adder-subtractor slice, one nibble per clock, least-significant nibble first. It owns the slice (four full_adder cells with explicit carry-in), the operand and result registers, the inter-nibble carry flop and the sequencing FSM. It gives the small-adder datapath a wide-operand, handshaked front end without widening the adder.

## Interface
- NIBBLES, 4, operand width in nibbles (≥1); W = 4*NIBBLES
- clk  in  1  rising-edge clock; only clock in the block
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- a  in  W  operand A, sampled on acceptance
- b  in  W  operand B, sampled on acceptance
- sub  in  1  0 = A+B, 1 = A−B; sampled on acceptance
- out_valid  out  1  result, cout and ovf valid
- out_ready  in  1  consumer takes result
- result  out  W  sum/difference mod 2^W
- cout  out  1  carry out of bit W−1 (for sub: 1 = no borrow, A ≥ B unsigned)
- ovf  out  1  two's-complement overflow

## Operation
- Acceptance: rising edge with in_valid=1 and in_ready=1. Latches a, b, sub; clears result; sets carry flop = sub; sets nibble index = 0.
- Slice per cycle: x = A[4i+3:4i], y = B[4i+3:4i] XOR {4{sub}}, cin = carry flop. Writes the 4-bit sum into result[4i+3:4i]. Loads cout of the slice into the carry flop.
- Last nibble (i = NIBBLES−1): cout = slice carry out; ovf = carry into bit 3 XOR carry out of bit 3. The slice exposes its bit-3 carry-in for this.
- FSM states:
  - IDLE: in_ready=1. Acceptance → RUN.
  - RUN: in_ready=0; one nibble per cycle; index increments. The edge that processes i = NIBBLES−1 → DONE.
  - DONE: out_valid=1; result, cout and ovf held stable. out_valid & out_ready at an edge → IDLE.
- in_ready is 1 only in IDLE. in_valid in RUN or DONE is ignored and has no effect.
- out_ready outside DONE is ignored.
- Index counter width: max(1, $clog2(NIBBLES)). It never exceeds NIBBLES−1 and does not wrap within an operation.
- result is defined only while out_valid=1. Partial nibbles are visible during RUN and must not be consumed.

## Timing
- Reset: rst_n=0 at any rising edge → IDLE, regardless of state (mid-RUN or DONE included). The in-flight operation is discarded. Clears result=0, cout=0, ovf=0, out_valid=0, carry flop=0, index=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after rst_n returns high.
- Latency: acceptance at edge E0; nibble i processed at edge E(i+1). out_valid rises after edge E(NIBBLES), i.e. NIBBLES cycles after acceptance.
- Minimum request-to-request period: NIBBLES+2 cycles (RUN × NIBBLES, one DONE cycle with out_ready=1, one IDLE cycle).
- Backpressure: with out_ready=0, DONE persists indefinitely and outputs hold.
- NIBBLES=1: RUN lasts exactly one cycle; behaviour is a registered 4-bit add/sub with handshake.
- All outputs are registered; no combinational path from inputs to outputs except in_ready (pure state decode).

## Test plan
- Reset: hold rst_n=0 for 3 cycles from any state → result=0x0000, cout=0, ovf=0, out_valid=0, in_ready=0 during reset; in_ready=1 on the first cycle after release.
- Add (NIBBLES=4): a=0x1234, b=0x0FCD, sub=0 → out_valid exactly 4 cycles after acceptance, result=0x2201, cout=0, ovf=0.
- Full carry ripple across nibbles: a=0xFFFF, b=0x0001, sub=0 → result=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → result=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 → result=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → result=0x7FFF, cout=1, ovf=1.
- Handshake:
  - in_valid held high with new operands during RUN → ignored; first result unchanged.
  - out_ready=0 for 5 cycles in DONE → out_valid and result held.
  - Next acceptance occurs no earlier than NIBBLES+2 cycles after the previous one.
- Reset mid-operation: rst_n=0 at the 2nd RUN edge → IDLE with all outputs cleared. A fresh request afterwards (0x0001+0x0002) yields 0x0003 with no residual carry.

Source files
------------

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/response bundle for the nibble-serial add/subtract controller.
// The requester owns the request side and out_ready; the controller owns the rest.
interface nibble_serial_addsub_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract computed on one shared 4-bit slice, one nibble per clock,
// least-significant nibble first, behind a valid/ready request and result handshake.
module nibble_serial_addsub_ctrl #(
   parameter int NIBBLES = 4
) (
   input logic                        clk,
   input logic                        rst_n,
   nibble_serial_addsub_ctrl_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic          armed;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          op_sub;
   logic          carry;
   logic [IW-1:0] idx;
   logic [W-1:0]  result_q;
   logic          cout_q;
   logic          ovf_q;
   logic          out_valid_q;

   logic [3:0]    x;
   logic [3:0]    y;
   logic          s0, s1, s2, s3;
   logic          c1, c2, c3, c4;
   logic          in_ready_w;

   function automatic logic [1:0] full_adder(input logic xi, input logic yi, input logic ci);
      return {(xi & yi) | (ci & (xi ^ yi)), xi ^ yi ^ ci};
   endfunction

   // Operands shift right each RUN cycle, so the current nibble is always at bits [3:0].
   assign x = op_a[3:0];
   assign y = op_b[3:0] ^ {4{op_sub}};

   assign {c1, s0} = full_adder(x[0], y[0], carry);
   assign {c2, s1} = full_adder(x[1], y[1], c1);
   assign {c3, s2} = full_adder(x[2], y[2], c2);
   assign {c4, s3} = full_adder(x[3], y[3], c3);

   // armed holds in_ready low while reset is asserted even though the state is already IDLE.
   assign in_ready_w    = (state == IDLE) && armed;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         armed       <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         op_sub      <= 1'b0;
         carry       <= 1'b0;
         idx         <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_w) begin
                  op_a     <= bus.a;
                  op_b     <= bus.b;
                  op_sub   <= bus.sub;
                  carry    <= bus.sub;
                  idx      <= '0;
                  result_q <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int n = 0; n < NIBBLES; n++) begin
                  if (idx == IW'(n)) begin
                     result_q[4*n +: 4] <= {s3, s2, s1, s0};
                  end
               end
               op_a  <= op_a >> 4;
               op_b  <= op_b >> 4;
               carry <= c4;
               // Overflow is the disagreement between carry into and out of the sign bit.
               if (idx == LAST_IDX) begin
                  cout_q      <= c4;
                  ovf_q       <= c3 ^ c4;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench: directed corner cases plus randomized requests compared
// against a plain-arithmetic reference of wide add/subtract with carry and overflow.
module tb_nibble_serial_addsub_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic clk = 1'b0;
   logic rst_n;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   lastAcc = -1000;

   nibble_serial_addsub_ctrl_if #(.NIBBLES(NIBBLES)) bus();

   nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock and a cycle stamp used to measure request spacing.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reference: {cout, ovf, result} from ordinary modular arithmetic and sign rules.
   function automatic logic [W+1:0] refModel(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         co;
      logic         ov;
      if (ts) begin
         r  = ta - tb2;
         co = (ta >= tb2);
         ov = (ta[W-1] != tb2[W-1]) && (r[W-1] != ta[W-1]);
      end else begin
         wide = {1'b0, ta} + {1'b0, tb2};
         r    = wide[W-1:0];
         co   = wide[W];
         ov   = (ta[W-1] == tb2[W-1]) && (r[W-1] != ta[W-1]);
      end
      return {co, ov, r};
   endfunction

   task automatic waitReady();
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                                input int hold, input bit junk);
      logic [W+1:0] exp;
      int           lat;
      exp = refModel(ta, tb2, ts);
      waitReady();
      bus.a        = ta;
      bus.b        = tb2;
      bus.sub      = ts;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("req_period", 32'(cyc - lastAcc >= NIBBLES + 2), 32'd1);
      lastAcc = cyc;
      // Optionally keep pushing unrelated requests that must be ignored.
      bus.in_valid = junk;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.sub      = 1'($urandom);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         checkOutput("run_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(NIBBLES));
      checkOutput("result", 32'(bus.result), 32'(exp[W-1:0]));
      checkOutput("cout", 32'(bus.cout), 32'(exp[W+1]));
      checkOutput("ovf", 32'(bus.ovf), 32'(exp[W]));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_result", 32'(bus.result), 32'(exp[W-1:0]));
         checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("drain_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_result"}, 32'(bus.result), 32'd0);
      checkOutput({tag, "_cout"}, 32'(bus.cout), 32'd0);
      checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checkCleared("rst");
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rel_in_ready", 32'(bus.in_ready), 32'd1);

      applyStimulus(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      applyStimulus(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
      applyStimulus(16'h1234, 16'h0FCD, 1'b0, 0, 1'b1);
      applyStimulus(16'hABCD, 16'h1111, 1'b1, 5, 1'b1);

      // Reset lands on the second RUN edge and must discard the partial result.
      waitReady();
      bus.a        = 16'hFFFF;
      bus.b        = 16'h0001;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkCleared("midrst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
      lastAcc = -1000;
      applyStimulus(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                       1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
